// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures the high time of a synchronised servo pulse,
// quantises it to one of 2**POS_BITS positions and flags bad pulses and signal loss.
module servo_pwm_decoder #(
   parameter int unsigned MIN_PULSE   = 50000,
   parameter int unsigned MAX_PULSE   = 100000,
   parameter int unsigned TOL         = 5000,
   parameter int unsigned TIMEOUT_CYC = 3000000,
   parameter int unsigned POS_BITS    = 2,
   parameter int unsigned CNT_W       = 22
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pwm_in,
   output logic [POS_BITS-1:0] position,
   output logic [CNT_W-1:0]    pulse_width,
   output logic                valid,
   output logic                error,
   output logic                signal_lost
);

   localparam int unsigned N_POS = 1 << POS_BITS;
   localparam int unsigned STEP  = (MAX_PULSE - MIN_PULSE) / (N_POS - 1);
   localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(MIN_PULSE - TOL);
   localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(MAX_PULSE + TOL);
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH} state_t;

   state_t              state_q, state_d;
   logic                sync1_q, sync1_d, sync2_q, sync2_d, s_dly_q, s_dly_d;
   logic [1:0]          primed_q, primed_d;
   logic [CNT_W-1:0]    high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
   logic [CNT_W-1:0]    pulse_width_q, pulse_width_d;
   logic [POS_BITS-1:0] position_q, position_d, pos_dec;
   logic                valid_q, valid_d, error_q, error_d, lost_q, lost_d;
   logic                s, rise, fall;

   assign s    = sync2_q;
   assign rise = s & ~s_dly_q;
   assign fall = ~s & s_dly_q;

   always_comb begin
      pos_dec = '0;
      for (int unsigned k = 1; k < N_POS; k++) begin
         if (high_cnt_q >= CNT_W'(MIN_PULSE + k * STEP - STEP / 2))
            pos_dec = pos_dec + POS_BITS'(1);
      end
   end

   always_comb begin
      sync1_d       = pwm_in;
      sync2_d       = sync1_q;
      s_dly_d       = sync2_q;
      // primed_q tracks when the reset-cleared synchroniser reflects the real pin,
      // so a pulse already high at reset release is not mistaken for a low.
      primed_d      = {primed_q[0], 1'b1};
      state_d       = state_q;
      high_cnt_d    = high_cnt_q;
      low_cnt_d     = low_cnt_q;
      pulse_width_d = pulse_width_q;
      position_d    = position_q;
      valid_d       = 1'b0;
      error_d       = 1'b0;
      lost_d        = lost_q;
      case (state_q)
         WAIT_LOW: begin
            if (primed_q[1] && !s) state_d = ARMED;
         end
         ARMED: begin
            if (rise) begin
               high_cnt_d = CNT_W'(1);
               low_cnt_d  = '0;
               state_d    = HIGH;
            end else if (low_cnt_q >= TO_LIM) begin
               lost_d = 1'b1;
            end else begin
               low_cnt_d = low_cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (fall) begin
               state_d = ARMED;
               if (high_cnt_q < LO_LIM) begin
                  error_d = 1'b1;
               end else begin
                  valid_d       = 1'b1;
                  pulse_width_d = high_cnt_q;
                  position_d    = pos_dec;
                  lost_d        = 1'b0;
               end
            end else if (high_cnt_q >= HI_LIM) begin
               error_d = 1'b1;
               state_d = WAIT_LOW;
            end else begin
               high_cnt_d = high_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = WAIT_LOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= WAIT_LOW;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         s_dly_q       <= 1'b0;
         primed_q      <= '0;
         high_cnt_q    <= '0;
         low_cnt_q     <= '0;
         pulse_width_q <= '0;
         position_q    <= '0;
         valid_q       <= 1'b0;
         error_q       <= 1'b0;
         lost_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         s_dly_q       <= s_dly_d;
         primed_q      <= primed_d;
         high_cnt_q    <= high_cnt_d;
         low_cnt_q     <= low_cnt_d;
         pulse_width_q <= pulse_width_d;
         position_q    <= position_d;
         valid_q       <= valid_d;
         error_q       <= error_d;
         lost_q        <= lost_d;
      end
   end

   assign position    = position_q;
   assign pulse_width = pulse_width_q;
   assign valid       = valid_q;
   assign error       = error_q;
   assign signal_lost = lost_q;

endmodule
